// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle RISC-V main control FSM. Sequences fetch, decode,
//               execute, memory and writeback, with memory timeout and traps.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       branch_taken_i,
    output logic [2:0] alu_op_o,
    output logic       alu_src_a_o,
    output logic       alu_src_b_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] mem_to_reg_o,
    output logic       instr_retired_o,
    output logic       trap_o,
    output logic [1:0] trap_cause_o,
    output logic [2:0] state_o
);

    localparam logic [2:0] c_ST_FETCH     = 3'd0;
    localparam logic [2:0] c_ST_DECODE    = 3'd1;
    localparam logic [2:0] c_ST_EXECUTE   = 3'd2;
    localparam logic [2:0] c_ST_MEM_READ  = 3'd3;
    localparam logic [2:0] c_ST_MEM_WRITE = 3'd4;
    localparam logic [2:0] c_ST_WRITEBACK = 3'd5;
    localparam logic [2:0] c_ST_TRAP      = 3'd7;

    localparam logic [2:0] c_OP_R    = 3'b000;
    localparam logic [2:0] c_OP_I    = 3'b001;
    localparam logic [2:0] c_OP_LUI  = 3'b010;
    localparam logic [2:0] c_OP_B    = 3'b011;
    localparam logic [2:0] c_OP_S    = 3'b100;
    localparam logic [2:0] c_OP_L    = 3'b101;
    localparam logic [2:0] c_OP_JAL  = 3'b110;
    localparam logic [2:0] c_OP_JALR = 3'b111;

    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b10;

    localparam logic [7:0] c_WAIT_LAST = 8'(WAIT_LIMIT - 1);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [2:0] r_alu_op;
    logic [2:0] w_dec_op;
    logic       w_dec_legal;
    logic [7:0] r_wait_cnt;
    logic [1:0] r_trap_cause;
    logic [1:0] w_trap_cause_next;
    logic       w_mem_state;
    logic       w_timeout;

    always_comb begin
        w_dec_legal = 1'b1;
        w_dec_op    = c_OP_R;
        case (opcode_i)
            7'b0110011: w_dec_op = c_OP_R;
            7'b0010011: w_dec_op = c_OP_I;
            7'b0110111: w_dec_op = c_OP_LUI;
            7'b1100011: w_dec_op = c_OP_B;
            7'b0100011: w_dec_op = c_OP_S;
            7'b0000011: w_dec_op = c_OP_L;
            7'b1101111: w_dec_op = c_OP_JAL;
            7'b1100111: w_dec_op = c_OP_JALR;
            default:    w_dec_legal = 1'b0;
        endcase
    end

    assign w_mem_state = (r_state == c_ST_FETCH) || (r_state == c_ST_MEM_READ) ||
                         (r_state == c_ST_MEM_WRITE);
    // Ready on the last allowed cycle still completes the access.
    assign w_timeout   = w_mem_state && !mem_ready_i && (r_wait_cnt == c_WAIT_LAST);

    always_comb begin
        w_next_state      = r_state;
        w_trap_cause_next = c_CAUSE_TIMEOUT;
        alu_src_a_o       = 1'b0;
        alu_src_b_o       = 1'b0;
        ir_write_o        = 1'b0;
        pc_write_o        = 1'b0;
        pc_src_o          = 2'b00;
        i_or_d_o          = 1'b0;
        mem_read_o        = 1'b0;
        mem_write_o       = 1'b0;
        reg_write_o       = 1'b0;
        mem_to_reg_o      = 2'b00;
        instr_retired_o   = 1'b0;

        case (r_state)
            c_ST_FETCH: begin
                mem_read_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o   = 1'b1;
                    pc_write_o   = 1'b1;
                    w_next_state = c_ST_DECODE;
                end else if (w_timeout) begin
                    w_next_state = c_ST_TRAP;
                end
            end
            c_ST_DECODE: begin
                if (w_dec_legal) begin
                    w_next_state = c_ST_EXECUTE;
                end else begin
                    w_next_state      = c_ST_TRAP;
                    w_trap_cause_next = c_CAUSE_ILLEGAL;
                end
            end
            c_ST_EXECUTE: begin
                alu_src_b_o = (r_alu_op != c_OP_R) && (r_alu_op != c_OP_B);
                alu_src_a_o = (r_alu_op == c_OP_JAL);
                case (r_alu_op)
                    c_OP_B: begin
                        pc_write_o      = branch_taken_i;
                        pc_src_o        = 2'b01;
                        instr_retired_o = 1'b1;
                        w_next_state    = c_ST_FETCH;
                    end
                    c_OP_L:  w_next_state = c_ST_MEM_READ;
                    c_OP_S:  w_next_state = c_ST_MEM_WRITE;
                    default: w_next_state = c_ST_WRITEBACK;
                endcase
            end
            c_ST_MEM_READ: begin
                i_or_d_o   = 1'b1;
                mem_read_o = 1'b1;
                if (mem_ready_i) begin
                    w_next_state = c_ST_WRITEBACK;
                end else if (w_timeout) begin
                    w_next_state = c_ST_TRAP;
                end
            end
            c_ST_MEM_WRITE: begin
                i_or_d_o    = 1'b1;
                mem_write_o = 1'b1;
                if (mem_ready_i) begin
                    instr_retired_o = 1'b1;
                    w_next_state    = c_ST_FETCH;
                end else if (w_timeout) begin
                    w_next_state = c_ST_TRAP;
                end
            end
            c_ST_WRITEBACK: begin
                reg_write_o     = 1'b1;
                instr_retired_o = 1'b1;
                w_next_state    = c_ST_FETCH;
                if (r_alu_op == c_OP_L) begin
                    mem_to_reg_o = 2'b01;
                end else if ((r_alu_op == c_OP_JAL) || (r_alu_op == c_OP_JALR)) begin
                    mem_to_reg_o = 2'b10;
                    pc_write_o   = 1'b1;
                    pc_src_o     = 2'b10;
                end
            end
            c_ST_TRAP: w_next_state = c_ST_TRAP;
            default:   w_next_state = c_ST_FETCH;
        endcase

        // Reset must kill strobes combinationally, even mid-access.
        if (reset) begin
            alu_src_a_o     = 1'b0;
            alu_src_b_o     = 1'b0;
            ir_write_o      = 1'b0;
            pc_write_o      = 1'b0;
            pc_src_o        = 2'b00;
            i_or_d_o        = 1'b0;
            mem_read_o      = 1'b0;
            mem_write_o     = 1'b0;
            reg_write_o     = 1'b0;
            mem_to_reg_o    = 2'b00;
            instr_retired_o = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_FETCH;
            r_alu_op     <= c_OP_R;
            r_wait_cnt   <= 8'd0;
            r_trap_cause <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_ST_DECODE) && w_dec_legal) begin
                r_alu_op <= w_dec_op;
            end
            if ((w_next_state == c_ST_TRAP) && (r_state != c_ST_TRAP)) begin
                r_trap_cause <= w_trap_cause_next;
            end
            // Staying in a memory state means another wait cycle; any move clears.
            if (w_mem_state && (w_next_state == r_state)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= 8'd0;
            end
        end
    end

    assign alu_op_o     = r_alu_op;
    assign trap_o       = (r_state == c_ST_TRAP);
    assign trap_cause_o = r_trap_cause;
    assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Scoreboard bench for multicycle_control with a phase-level
//               reference model and randomized instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    localparam int WAIT_LIMIT = 15;

    typedef struct packed {
        logic [2:0] state;
        logic [2:0] alu_op;
        logic       src_a;
        logic       src_b;
        logic       ir_w;
        logic       pc_w;
        logic [1:0] pc_src;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       rw;
        logic [1:0] m2r;
        logic       ret;
        logic       trap;
        logic [1:0] cause;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode_i;
    logic       mem_ready_i;
    logic       branch_taken_i;
    logic [2:0] alu_op_o;
    logic       alu_src_a_o;
    logic       alu_src_b_o;
    logic       ir_write_o;
    logic       pc_write_o;
    logic [1:0] pc_src_o;
    logic       i_or_d_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       reg_write_o;
    logic [1:0] mem_to_reg_o;
    logic       instr_retired_o;
    logic       trap_o;
    logic [1:0] trap_cause_o;
    logic [2:0] state_o;

    int   n_checks    = 0;
    int   n_errors    = 0;
    int   n_ret_exp   = 0;
    int   n_ret_act   = 0;
    exp_t exp_q[$];

    logic [2:0] m_alu_op = 3'b000;
    logic [1:0] m_cause  = 2'b00;

    multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk             (clk),
        .reset           (reset),
        .opcode_i        (opcode_i),
        .mem_ready_i     (mem_ready_i),
        .branch_taken_i  (branch_taken_i),
        .alu_op_o        (alu_op_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .ir_write_o      (ir_write_o),
        .pc_write_o      (pc_write_o),
        .pc_src_o        (pc_src_o),
        .i_or_d_o        (i_or_d_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .reg_write_o     (reg_write_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .instr_retired_o (instr_retired_o),
        .trap_o          (trap_o),
        .trap_cause_o    (trap_cause_o),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t sample();
        exp_t a;
        a = {state_o, alu_op_o, alu_src_a_o, alu_src_b_o, ir_write_o, pc_write_o,
             pc_src_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o,
             instr_retired_o, trap_o, trap_cause_o};
        return a;
    endfunction

    // Monitor: every cycle with a pending expectation is compared.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = sample();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL cycle_outputs t=%0t state_exp=%0d got=%h want=%h",
                         $time, e.state, a, e);
            end
        end
        if (instr_retired_o === 1'b1) n_ret_act++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic bit classify(input logic [6:0] op, output logic [2:0] cls);
        cls = 3'b000;
        case (op)
            7'b0110011: cls = 3'b000;
            7'b0010011: cls = 3'b001;
            7'b0110111: cls = 3'b010;
            7'b1100011: cls = 3'b011;
            7'b0100011: cls = 3'b100;
            7'b0000011: cls = 3'b101;
            7'b1101111: cls = 3'b110;
            7'b1100111: cls = 3'b111;
            default:    return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic exp_t base(input logic [2:0] st);
        exp_t e;
        e        = '0;
        e.state  = st;
        e.alu_op = m_alu_op;
        e.cause  = m_cause;
        e.trap   = (st == 3'd7);
        return e;
    endfunction

    task automatic step(input exp_t e);
        if (e.ret) n_ret_exp++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit chk_mw);
        exp_t z;
        z = '0;
        if (chk_mw) begin
            #1;
            n_checks++;
            if (mem_write_o !== 1'b1) begin
                n_errors++;
                $display("FAIL mw_before_reset got=%b want=1", mem_write_o);
            end
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (sample() !== z) begin
            n_errors++;
            $display("FAIL async_reset_outputs got=%h want=%h", sample(), z);
        end
        m_alu_op = 3'b000;
        m_cause  = 2'b00;
        @(posedge clk);
        #1;
        step(z);
        reset = 1'b0;
    endtask

    task automatic trap_run();
        exp_t e;
        for (int i = 0; i < 20; i++) begin
            opcode_i       = 7'($urandom);
            mem_ready_i    = 1'($urandom);
            branch_taken_i = 1'($urandom);
            e = base(3'd7);
            step(e);
        end
        do_reset(1'b0);
    endtask

    // One memory-style phase: 'waits' low-ready cycles, then a ready cycle,
    // unless the wait limit is reached first.
    task automatic mem_phase(input logic [2:0] st, input int waits, output bit trapped);
        exp_t e;
        trapped = 1'b0;
        for (int k = 0; ; k++) begin
            e      = base(st);
            e.mr   = (st != 3'd4);
            e.mw   = (st == 3'd4);
            e.iord = (st != 3'd0);
            if (k < waits) begin
                mem_ready_i = 1'b0;
                step(e);
                if (k == WAIT_LIMIT - 1) begin
                    m_cause = 2'b10;
                    trapped = 1'b1;
                    return;
                end
            end else begin
                mem_ready_i = 1'b1;
                if (st == 3'd0) begin
                    e.ir_w = 1'b1;
                    e.pc_w = 1'b1;
                end
                if (st == 3'd4) e.ret = 1'b1;
                step(e);
                return;
            end
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input bit taken, input bit abort);
        exp_t       e;
        bit         trapped;
        logic [2:0] cls;
        bit         legal;
        opcode_i       = 7'($urandom);
        branch_taken_i = 1'($urandom);
        mem_phase(3'd0, fw, trapped);
        if (trapped) begin
            trap_run();
            return;
        end
        opcode_i       = op;
        mem_ready_i    = 1'($urandom);
        branch_taken_i = 1'($urandom);
        legal = classify(op, cls);
        step(base(3'd1));
        if (!legal) begin
            m_cause = 2'b01;
            trap_run();
            return;
        end
        m_alu_op       = cls;
        branch_taken_i = taken;
        mem_ready_i    = 1'($urandom);
        e       = base(3'd2);
        e.src_b = (cls != 3'b000) && (cls != 3'b011);
        e.src_a = (cls == 3'b110);
        if (cls == 3'b011) begin
            e.pc_w   = taken;
            e.pc_src = 2'b01;
            e.ret    = 1'b1;
            step(e);
            return;
        end
        step(e);
        if (cls == 3'b100) begin
            if (abort) begin
                mem_ready_i = 1'b0;
                do_reset(1'b1);
                return;
            end
            mem_phase(3'd4, mw, trapped);
            if (trapped) trap_run();
            return;
        end
        if (cls == 3'b101) begin
            mem_phase(3'd3, mw, trapped);
            if (trapped) begin
                trap_run();
                return;
            end
        end
        mem_ready_i = 1'($urandom);
        e     = base(3'd5);
        e.rw  = 1'b1;
        e.ret = 1'b1;
        if (cls == 3'b101) e.m2r = 2'b01;
        if (cls == 3'b110 || cls == 3'b111) begin
            e.m2r    = 2'b10;
            e.pc_w   = 1'b1;
            e.pc_src = 2'b10;
        end
        step(e);
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 39));
        if (r == 39) return WAIT_LIMIT;
        if (r >= 37) return WAIT_LIMIT - 1;
        return int'($urandom_range(0, 3));
    endfunction

    logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b1100011,
                                  7'b0100011, 7'b0000011, 7'b1101111, 7'b1100111};

    initial begin
        logic [6:0] op;
        logic [2:0] dummy;
        reset          = 1'b1;
        opcode_i       = 7'd0;
        mem_ready_i    = 1'b1;
        branch_taken_i = 1'b0;
        @(posedge clk);
        #1;
        step('0);
        reset = 1'b0;

        run_instr(7'b0110011, 0, 0, 1'b0, 1'b0);
        run_instr(7'b0000011, 0, 3, 1'b0, 1'b0);
        run_instr(7'b1100011, 0, 0, 1'b1, 1'b0);
        run_instr(7'b1100011, 0, 0, 1'b0, 1'b0);
        run_instr(7'b1101111, 0, 0, 1'b0, 1'b0);
        run_instr(7'b1111111, 0, 0, 1'b0, 1'b0);
        run_instr(7'b0110011, WAIT_LIMIT, 0, 1'b0, 1'b0);
        run_instr(7'b0110011, WAIT_LIMIT - 1, 0, 1'b0, 1'b0);
        run_instr(7'b0000011, 1, WAIT_LIMIT, 1'b0, 1'b0);
        run_instr(7'b0100011, 0, WAIT_LIMIT - 1, 1'b0, 1'b0);
        run_instr(7'b0000011, 0, 0, 1'b0, 1'b0);
        run_instr(7'b0100011, 0, 0, 1'b0, 1'b1);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                do op = 7'($urandom); while (classify(op, dummy));
            end else begin
                op = legal_ops[$urandom_range(0, 7)];
            end
            run_instr(op, pick_wait(), pick_wait(), 1'($urandom),
                      ($urandom_range(0, 19) == 0));
        end

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        n_checks++;
        if (n_ret_act != n_ret_exp) begin
            n_errors++;
            $display("FAIL retire_count got=%0d want=%0d", n_ret_act, n_ret_exp);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle RISC-V main control FSM; sits directly upstream of the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath strobe and mux select, plus the 3-bit ALU_Op code that the ALU control decoder combines with funct3/funct7.
- Handles memory wait states with a timeout, and traps on illegal opcodes.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive mem_ready_i-low cycles allowed in one memory state. Legal range 1..255; wait counter is 8 bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode_i  input  7  instruction[6:0] from the IR; valid from DECODE onward
- mem_ready_i  input  1  memory handshake: access completes this cycle
- branch_taken_i  input  1  ALU compare result; valid in EXECUTE for B-type
- alu_op_o  output  3  ALU_Op to the ALU control decoder
- alu_src_a_o  output  1  0 = rs1, 1 = PC_old
- alu_src_b_o  output  1  0 = rs2, 1 = immediate
- ir_write_o  output  1  load IR
- pc_write_o  output  1  load PC
- pc_src_o  output  2  00 = PC+4, 01 = branch target adder, 10 = ALU result
- i_or_d_o  output  1  memory address select: 0 = PC, 1 = ALU result
- mem_read_o  output  1  memory read request
- mem_write_o  output  1  memory write request
- reg_write_o  output  1  register file write enable
- mem_to_reg_o  output  2  writeback select: 00 = ALU, 01 = memory data, 10 = PC (link)
- instr_retired_o  output  1  one-cycle pulse per completed instruction
- trap_o  output  1  sticky trap flag
- trap_cause_o  output  2  01 = illegal opcode, 10 = memory timeout
- state_o  output  3  current state, for debug

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to FETCH; the wait counter clears.
  - alu_op_o = 000; trap_o = 0; trap_cause_o = 00.
  - All strobes (ir_write_o, pc_write_o, mem_read_o, mem_write_o, reg_write_o, instr_retired_o) = 0.
  - All selects (alu_src_a_o, alu_src_b_o, pc_src_o, i_or_d_o, mem_to_reg_o) = 0.
  - Strobes drop in the same cycle reset asserts, including mid-access.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM_READ=3, MEM_WRITE=4, WRITEBACK=5, TRAP=7.
- Outputs are decoded from the current state. Exceptions: ir_write_o, pc_write_o and instr_retired_o are also qualified by mem_ready_i / branch_taken_i as listed below.
- FETCH:
  - mem_read_o = 1, i_or_d_o = 0.
  - When mem_ready_i = 1: ir_write_o = 1, pc_write_o = 1, pc_src_o = 00; next state DECODE.
- DECODE:
  - Classify opcode_i and register alu_op_o at the DECODE->EXECUTE edge. alu_op_o holds that value until the next DECODE.
  - Opcode to ALU_Op map:
    - 0110011 R -> 000
    - 0010011 I-arith -> 001
    - 0110111 LUI -> 010
    - 1100011 B -> 011
    - 0100011 S -> 100
    - 0000011 L -> 101
    - 1101111 JAL -> 110
    - 1100111 JALR -> 111
  - Any other opcode: next state TRAP, trap_cause_o = 01, alu_op_o unchanged.
- EXECUTE:
  - alu_src_b_o = 0 for R and B, 1 otherwise.
  - alu_src_a_o = 1 for JAL only.
  - Next state by class:
    - R / I / LUI / JAL / JALR -> WRITEBACK
    - L -> MEM_READ
    - S -> MEM_WRITE
    - B -> FETCH, with pc_write_o = branch_taken_i, pc_src_o = 01, instr_retired_o = 1
- MEM_READ / MEM_WRITE:
  - i_or_d_o = 1; mem_read_o or mem_write_o held high until mem_ready_i = 1.
  - MEM_READ then goes to WRITEBACK.
  - MEM_WRITE then goes to FETCH with instr_retired_o = 1.
- WRITEBACK:
  - reg_write_o = 1, instr_retired_o = 1; next state FETCH.
  - mem_to_reg_o: 01 for L, 10 for JAL/JALR, 00 otherwise.
  - JAL/JALR also assert pc_write_o = 1 with pc_src_o = 10. The ALU result is the target register latched in EXECUTE.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments on each cycle spent in those states with mem_ready_i = 0.
  - If mem_ready_i = 0 on a cycle where the counter equals WAIT_LIMIT-1: next state TRAP, trap_cause_o = 10.
  - mem_ready_i = 1 on that same cycle completes the access normally (ready wins).
- TRAP:
  - Absorbing state: trap_o = 1, trap_cause_o held, all strobes 0.
  - Left only by reset.
  - opcode_i and mem_ready_i are ignored.

Test Plan:
1. Reset, opcode 0110011, mem_ready_i = 1 constantly -> state sequence 0,1,2,5,0 over 4 cycles; alu_op_o = 000 in EXECUTE; reg_write_o = 1 and one instr_retired_o pulse in WRITEBACK.
2. Opcode 0000011, mem_ready_i low 3 cycles in MEM_READ -> mem_read_o and i_or_d_o high 4 cycles; alu_op_o = 101; mem_to_reg_o = 01 in WRITEBACK; 8 cycles total.
3. Opcode 1100011 with branch_taken_i = 1, then = 0 -> alu_op_o = 011; 3 cycles each; pc_write_o with pc_src_o = 01 in EXECUTE only when taken; reg_write_o never asserted. Repeat with 1101111 -> alu_op_o = 110, alu_src_a_o = 1, WRITEBACK with mem_to_reg_o = 10, pc_src_o = 10.
4. Opcode 1111111 -> TRAP one cycle after DECODE, trap_cause_o = 01, state_o = 7; stays there for 20 cycles with no strobes; reset returns to FETCH.
5. WAIT_LIMIT = 15, mem_ready_i low in FETCH: 15 low cycles -> TRAP with trap_cause_o = 10. Separate run: ready rises on the 15th cycle -> no trap, normal DECODE.
6. Reset asserted mid-MEM_WRITE, off the clock edge -> mem_write_o falls immediately; after release, state FETCH and alu_op_o = 000.
